// File: rtl/cache_pkg.sv
// Shared widths, address-field helpers and controller state encoding for the
// direct-mapped instruction cache.
package cache_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int INDEX_BITS  = 6;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_W       = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int LINE_W      = ADDR_W - OFFSET_BITS;
  localparam int LINES       = 1 << INDEX_BITS;
  localparam int WORDS       = 1 << OFFSET_BITS;

  typedef logic [TAG_W-1:0]       tag_t;
  typedef logic [INDEX_BITS-1:0]  index_t;
  typedef logic [OFFSET_BITS-1:0] offset_t;
  typedef logic [LINE_W-1:0]      line_t;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    FILL,
    RESTART
  } state_t;

  function automatic tag_t tag_of(line_t line);
    return line[LINE_W-1:INDEX_BITS];
  endfunction

  function automatic index_t index_of(line_t line);
    return line[INDEX_BITS-1:0];
  endfunction

endpackage

// File: rtl/prog_cache_if.sv
// Fetch-side and SDRAM-fill-side signals of the instruction cache; the CPU /
// memory side is the master, the cache is the slave.
interface prog_cache_if;

  logic [cache_pkg::ADDR_W-1:0] A;
  logic                         flush;
  logic [cache_pkg::DATA_W-1:0] I;
  logic                         p_cache_miss;
  logic                         mem_req;
  logic [cache_pkg::ADDR_W-1:0] mem_addr;
  logic                         mem_ready;
  logic [cache_pkg::DATA_W-1:0] mem_data;

  modport master (
    output A, flush, mem_ready, mem_data,
    input  I, p_cache_miss, mem_req, mem_addr
  );

  modport slave (
    input  A, flush, mem_ready, mem_data,
    output I, p_cache_miss, mem_req, mem_addr
  );

endinterface

// File: rtl/cache_ram.sv
// Single-port RAM with synchronous read; read data appears the cycle after
// the address is presented.
module cache_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  // NOTE: the storage array has no reset; a reset loop over a memory stops it
  // mapping onto a RAM macro, and line validity is tracked elsewhere.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/prog_cache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, line refill from
// SDRAM on a miss, with p_cache_miss as the only stall seen by the PC.
module prog_cache
  import cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  prog_cache_if.slave  bus
);

  state_t              r_state, w_next;
  line_t               r_line_q;
  line_t               r_miss_line;
  index_t              r_clr_idx;
  offset_t             r_word_cnt;
  logic                r_flush_pend;
  logic [LINES-1:0]    r_valid;
  logic [DATA_W-1:0]   r_i;

  tag_t                w_tag_rd;
  logic [DATA_W-1:0]   w_data_rd;
  logic                w_hit;
  logic                w_run_hit;
  logic                w_fill_wr;
  logic                w_fill_last;
  logic [INDEX_BITS+OFFSET_BITS-1:0] w_data_addr;
  index_t              w_tag_addr;
  logic [DATA_W-1:0]   w_i;

  // Fills own the RAM ports; every other state reads at the live fetch address.
  assign w_fill_wr   = (r_state == FILL) & bus.mem_ready;
  assign w_fill_last = w_fill_wr & (r_word_cnt == offset_t'(WORDS-1));
  assign w_data_addr = (r_state == FILL) ? {index_of(r_miss_line), r_word_cnt}
                                         : bus.A[INDEX_BITS+OFFSET_BITS-1:0];
  assign w_tag_addr  = (r_state == FILL) ? index_of(r_miss_line)
                                         : bus.A[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];

  cache_ram #(.AW(INDEX_BITS+OFFSET_BITS), .DW(DATA_W)) u_data_ram (
    .clk     (clk),
    .i_we    (w_fill_wr),
    .i_addr  (w_data_addr),
    .i_wdata (bus.mem_data),
    .o_rdata (w_data_rd)
  );

  cache_ram #(.AW(INDEX_BITS), .DW(TAG_W)) u_tag_ram (
    .clk     (clk),
    .i_we    (w_fill_last),
    .i_addr  (w_tag_addr),
    .i_wdata (tag_of(r_miss_line)),
    .o_rdata (w_tag_rd)
  );

  assign w_hit     = r_valid[index_of(r_line_q)] & (w_tag_rd == tag_of(r_line_q));
  assign w_run_hit = (r_state == RUN) & w_hit;
  assign w_i       = w_run_hit ? w_data_rd : r_i;

  assign bus.I            = w_i;
  assign bus.p_cache_miss = ~w_run_hit;
  assign bus.mem_req      = (r_state == FILL);
  assign bus.mem_addr     = {r_miss_line, {OFFSET_BITS{1'b0}}};

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CLEAR:   if (!bus.flush && r_clr_idx == index_t'(LINES-1)) w_next = RESTART;
      RUN:     if (bus.flush) w_next = CLEAR;
               else if (!w_hit) w_next = FILL;
      FILL:    if (w_fill_last) w_next = (r_flush_pend | bus.flush) ? CLEAR : RESTART;
      RESTART: w_next = bus.flush ? CLEAR : RUN;
      default: w_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= CLEAR;
      r_line_q     <= '0;
      r_miss_line  <= '0;
      r_clr_idx    <= '0;
      r_word_cnt   <= '0;
      r_flush_pend <= 1'b0;
      r_i          <= '0;
    end else begin
      r_state  <= w_next;
      r_line_q <= bus.A[ADDR_W-1:OFFSET_BITS];
      r_i      <= w_i;

      if (r_state == CLEAR && !bus.flush) r_clr_idx <= r_clr_idx + index_t'(1);
      else                                r_clr_idx <= '0;

      if (r_state == RUN && w_next == FILL) begin
        r_miss_line  <= r_line_q;
        r_word_cnt   <= '0;
        r_flush_pend <= 1'b0;
      end else if (r_state == FILL) begin
        if (bus.mem_ready) r_word_cnt <= r_word_cnt + offset_t'(1);
        if (bus.flush)     r_flush_pend <= 1'b1;
      end
    end
  end

  // Valid bits are cleared by the sweep rather than by reset, so reset only
  // has to park the controller in CLEAR.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) r_valid[r_clr_idx] <= 1'b0;
      if (w_fill_last)      r_valid[index_of(r_miss_line)] <= 1'b1;
    end
  end

endmodule

// File: doc/prog_cache.md
Name: prog_cache

Overview:
- Instruction-side responder to the CPU fetch address bus: takes the 16-bit fetch address A and returns the instruction word one cycle later.
- Direct-mapped, read-only cache between the fetch address and the SDRAM controller's read port.
- Asserts p_cache_miss for the whole of each line refill. Holding p_cache_miss is the only stall mechanism the PC sees.

Parameters:
- ADDR_W, 16, fetch/memory address width in words.
- DATA_W, 16, instruction word width.
- INDEX_BITS, 6, line index bits (64 lines).
- OFFSET_BITS, 2, word-in-line bits (4 words per line).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- A  in  ADDR_W  fetch address from PC, sampled every clk
- flush  in  1  one-cycle pulse: invalidate all lines
- I  out  DATA_W  instruction for the address sampled on the previous edge
- p_cache_miss  out  1  stall/miss indication to PC
- mem_req  out  1  line-fill request to SDRAM controller
- mem_addr  out  ADDR_W  line base address {tag,index,OFFSET_BITS'b0}, stable while mem_req=1
- mem_ready  in  1  one strobe per returned word, in order from offset 0
- mem_data  in  DATA_W  fill word, valid with mem_ready

Behaviour:
- Address fields: tag = A[ADDR_W-1:INDEX_BITS+OFFSET_BITS], index = A[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS], offset = low bits.
- Storage:
  - data RAM of 2^(INDEX_BITS+OFFSET_BITS) x DATA_W; tag RAM of 2^INDEX_BITS x tag width; both with synchronous read.
  - valid bits held in flops.
- Reset:
  - state=CLEAR, mem_req=0, mem_addr=0, I=0, p_cache_miss=1, valid bits cleared by the CLEAR sweep.
  - Reset mid-fill drops mem_req in the next cycle and discards the partial line.
- State CLEAR:
  - walks the index counter 0..2^INDEX_BITS-1, one valid bit cleared per cycle; p_cache_miss=1.
  - On the last index, goes to RESTART.
- State RUN:
  - each edge registers A into A_q and issues RAM reads at A.
  - The next cycle compares the tag-RAM output with A_q's tag. hit = valid[index_q] & tag match.
  - Hit: I = data RAM output, p_cache_miss=0, latency exactly 1 cycle.
  - Miss: p_cache_miss=1 combinationally in that same cycle; goes to FILL at the next edge, latching miss_addr=A_q.
- State FILL:
  - mem_req=1, mem_addr = line base of miss_addr, p_cache_miss=1.
  - Each mem_ready writes mem_data at {index,word_cnt} and increments word_cnt (OFFSET_BITS wide, wraps to 0 after the last word).
  - On the last word: write the tag, set the valid bit, mem_req=0 at the next edge, go to RESTART.
  - mem_ready outside FILL is ignored.
- State RESTART:
  - one cycle; re-reads the RAMs at the current A (the PC is replaying the miss address); p_cache_miss=1.
  - Goes to RUN. The first RUN compare uses this read.
- p_cache_miss = (state != RUN) | ~hit.
- I holds its last value while p_cache_miss=1 and is don't-care for the PC.
- flush handling:
  - In RUN: takes effect at the next edge (go to CLEAR).
  - In FILL: sets flush_pend; the fill completes (the line is written), then CLEAR runs instead of RESTART.
  - In CLEAR: restarts the sweep from index 0.
- Simultaneous RAM write (fill) and lookup cannot occur; lookups happen only in RUN.

Decomposition:
- Shared package cache_pkg: state encoding (CLEAR, RUN, FILL, RESTART) and field-width constants derived from the parameters.
- One natural sub-module, cache_ram: a synchronous single-port RAM, instantiated twice (data, tag).

Test Plan:
- Reset then A=0x0000 → p_cache_miss=1 through the 64-cycle CLEAR, then FILL with mem_addr=0x0000. Return words 0x1111, 0x2222, 0x3333, 0x4444 → after RESTART, I=0x1111 with p_cache_miss=0.
- After that fill, A=0x0001, 0x0002, 0x0003 on consecutive cycles → I=0x2222, 0x3333, 0x4444 one cycle later each, with no miss.
- A=0x0100 (same index 0, different tag) → miss, mem_addr=0x0100. After the fill, A=0x0000 misses again (eviction).
- Fill in progress with mem_ready gapped (strobes every 3 cycles) → mem_req stays high, mem_addr stays stable, and exactly 4 writes occur.
- flush pulse during FILL → the fill completes, the CLEAR sweep follows, and the next A=0x0000 misses.
- rst pulse after 2 of 4 fill words → mem_req=0 next cycle; after CLEAR, that line reads as a miss.
